// File: rtl/netbus_pkg.sv
// rtl/netbus_pkg.sv - shared NetBus widths, state encoding and one-hot helper.
package netbus_pkg;

  localparam int EOF_BIT = 0;

  typedef enum logic {IDLE, XFER} nb_state_e;

  function automatic int NB_W(input int dw);
    return dw * 9 + 14;
  endfunction

  function automatic logic [1:0] nb_idx(input logic [3:0] oh);
    nb_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) nb_idx = 2'(i);
  endfunction

endpackage

// File: rtl/netbus_rr_pick.sv
// rtl/netbus_rr_pick.sv - 4-way round-robin picker, search starts one past the pointer.
module netbus_rr_pick (
  input  logic [3:0] request,
  input  logic [1:0] pointer,
  output logic [3:0] grant,
  output logic       valid
);

  logic [1:0] idx;

  // Walk from farthest to nearest so the nearest requester after pointer wins.
  always_comb begin
    grant = 4'b0000;
    idx   = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = pointer + 2'(k);
      if (request[idx]) grant = 4'b0001 << idx;
    end
  end

  assign valid = |request;

endmodule

// File: rtl/netbus_frame_arbiter.sv
// rtl/netbus_frame_arbiter.sv - frame-granular 4:1 NetBus arbiter, real-time first, starvation promotion.
module netbus_frame_arbiter
  import netbus_pkg::*;
#(
  parameter int         DATA_WIDTH   = 4,
  parameter logic [3:0] RT_MASK      = 4'b0000,
  parameter int         STARVE_LIMIT = 8
) (
  input  logic                              RCLK,
  input  logic                              RESETn,
  input  logic [4*NB_W(DATA_WIDTH)-1:0]     IN_DATA,
  input  logic [3:0]                        IN_VALID,
  input  logic [3:0]                        IN_FRAME,
  output logic [3:0]                        IN_READY,
  output logic [NB_W(DATA_WIDTH)-1:0]       OUT_DATA,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic [3:0]                        GRANT,
  output logic                              BUSY,
  output logic                              PROMOTED
);

  localparam int W = NB_W(DATA_WIDTH);

  nb_state_e  state;
  logic [1:0] rr_rt, rr_norm;
  logic [7:0] starve_cnt [4];

  logic [3:0] elig, rt_req, norm_elig, starved, norm_req;
  logic [3:0] rt_gnt, nm_gnt, win;
  logic       rt_vld, nm_vld, any_starved, win_is_rt, arb_go;
  logic [1:0] win_idx, g_idx;

  assign elig      = (RT_MASK & IN_VALID) | (~RT_MASK & IN_FRAME);
  assign rt_req    = elig & RT_MASK;
  assign norm_elig = elig & ~RT_MASK;

  always_comb begin
    starved = 4'b0000;
    for (int i = 0; i < 4; i++)
      starved[i] = norm_elig[i] && (starve_cnt[i] >= 8'(STARVE_LIMIT));
  end

  // The normal picker doubles as the promotion picker when any port is starved.
  assign any_starved = |starved;
  assign norm_req    = any_starved ? starved : norm_elig;

  netbus_rr_pick u_pick_rt (
    .request (rt_req),
    .pointer (rr_rt),
    .grant   (rt_gnt),
    .valid   (rt_vld)
  );

  netbus_rr_pick u_pick_norm (
    .request (norm_req),
    .pointer (rr_norm),
    .grant   (nm_gnt),
    .valid   (nm_vld)
  );

  assign win_is_rt = !any_starved && rt_vld;
  assign win       = win_is_rt ? rt_gnt : nm_gnt;
  assign win_idx   = nb_idx(win);
  assign arb_go    = rt_vld | nm_vld;

  assign g_idx     = nb_idx(GRANT);
  assign BUSY      = (state == XFER);
  assign OUT_DATA  = IN_DATA[int'(g_idx)*W +: W];
  assign OUT_VALID = BUSY && IN_VALID[g_idx];
  assign IN_READY  = BUSY ? (GRANT & {4{OUT_READY}}) : 4'b0000;

  always_ff @(posedge RCLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      GRANT    <= 4'b0000;
      PROMOTED <= 1'b0;
      rr_rt    <= 2'd3;
      rr_norm  <= 2'd3;
      for (int i = 0; i < 4; i++) starve_cnt[i] <= 8'd0;
    end else begin
      PROMOTED <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_go) begin
            state    <= XFER;
            GRANT    <= win;
            PROMOTED <= any_starved;
            if (win_is_rt) rr_rt   <= win_idx;
            else           rr_norm <= win_idx;
            for (int i = 0; i < 4; i++) begin
              if (win[i])
                starve_cnt[i] <= 8'd0;
              else if (norm_elig[i] && starve_cnt[i] != 8'd255)
                starve_cnt[i] <= starve_cnt[i] + 8'd1;
            end
          end
        end
        XFER: begin
          if (OUT_VALID && OUT_READY && OUT_DATA[EOF_BIT]) begin
            state <= IDLE;
            GRANT <= 4'b0000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/netbus_frame_arbiter.md
# netbus_frame_arbiter

Frame-granular arbiter that merges four NetBus receive-slice outputs, already synchronised into the RCLK domain, onto one NetBus stream. It sits between the per-port receive slices and the downstream NetBus consumer. It schedules real-time ports ahead of normal ports and uses round-robin within each class. An anti-starvation counter promotes a normal port that has waited too long. A granted port is never pre-empted mid-frame.

## Interface
- DATA_WIDTH, 4: NetBus payload width unit; bus word is DATA_WIDTH*9+14 bits.
- RT_MASK, 4'b0000: bit i = 1 makes port i real-time (eligible on `IN_VALID[i]`); else eligible on `IN_FRAME[i]` (complete frame buffered).
- STARVE_LIMIT, 8: grants a waiting eligible normal port tolerates before promotion; 1..255.
- RCLK  in  1  clock; all logic single-domain.
- RESETn  in  1  asynchronous, active-low reset.
- IN_DATA  in  4*(DATA_WIDTH*9+14)  port i in slice [i*W +: W]; bit 0 of each word = end-of-frame (EOF).
- IN_VALID  in  4  per-port word valid.
- IN_FRAME  in  4  per-port complete-frame-available.
- IN_READY  out  4  per-port ready; only the granted bit may be high.
- OUT_DATA  out  DATA_WIDTH*9+14  merged word.
- OUT_VALID  out  1  merged valid.
- OUT_READY  in  1  downstream ready.
- GRANT  out  4  one-hot current grant; 0 when idle.
- BUSY  out  1  high in XFER state.
- PROMOTED  out  1  one-cycle pulse when a grant was issued by starvation promotion.

## Operation
- Eligibility: `elig[i] = RT_MASK[i] ? IN_VALID[i] : IN_FRAME[i]`.
- FSM states:
  - IDLE: if any `elig`, register the winner into GRANT and go to XFER; else stay.
  - XFER: pass-through until an EOF word is accepted (`OUT_VALID & OUT_READY & OUT_DATA[0]`), then GRANT <= 0 and go to IDLE.
- Winner selection priority:
  1. Any eligible normal port whose starve counter ≥ STARVE_LIMIT. Lowest such index after `rr_norm`. Pulse PROMOTED.
  2. Eligible real-time ports, round-robin starting at `rr_rt + 1`.
  3. Eligible normal ports, round-robin starting at `rr_norm + 1`.
- Pointers: `rr_rt` / `rr_norm` (2 bits each, wrap 3→0) update to the granted index only for their own class; promotion updates `rr_norm`.
- Starve counters: one 8-bit counter per normal port.
  - On every grant, increment (saturating at 255) for each normal port that is eligible but not granted.
  - Clear the granted port's counter.
  - Counters of ineligible ports hold.
  - Real-time ports have no counter.
- Datapath in XFER (combinational mux on GRANT): `OUT_DATA = IN_DATA[g]`, `OUT_VALID = IN_VALID[g]`, `IN_READY[g] = OUT_READY`; other IN_READY bits are 0. In IDLE, OUT_VALID = 0, IN_READY = 0, and OUT_DATA = port 0 data (don't-care).

## Timing
- Reset values: state IDLE, GRANT = 0, BUSY = 0, PROMOTED = 0, OUT_VALID = 0, IN_READY = 0, `rr_rt` = `rr_norm` = 3 (so port 0 wins first), all starve counters 0.
- Arbitration latency: `elig` sampled in IDLE at edge n → first word can transfer in cycle n+1.
- At least one IDLE cycle between consecutive frames, even from the same port.
- Single-word frames (EOF on the first word) are legal: XFER lasts exactly one accepted beat.
- The granted port dropping IN_VALID mid-frame stalls the output; there is no timeout and no pre-emption. Eligibility changes on other ports during XFER are ignored.
- Simultaneous eligibility is resolved solely by the priority rules above, all in the same cycle.
- RESETn asserted mid-frame aborts immediately to the reset state. The partial frame is not completed; upstream recovery is the slices' concern.
- OUT_READY low while OUT_VALID high: OUT_DATA and GRANT hold.

## Structure
- Shared package `netbus_pkg`: word-width function `NB_W(DATA_WIDTH) = DATA_WIDTH*9+14`, EOF bit index constant (0), state enum {IDLE, XFER}.
- Sub-module `netbus_rr_pick`: 4-way round-robin picker (request[3:0], pointer[1:0] → one-hot, valid). Instantiated twice: real-time class and normal class (promotion path reuses the normal picker with the starved-port mask).
- Expected RTL size: ~200 lines.

## Test plan
- Reset, then all ports idle → GRANT = 0, OUT_VALID = 0, IN_READY = 0 indefinitely.
- RT_MASK = 0; ports 0–3 each hold one 3-word frame simultaneously → grants in order 0, 1, 2, 3. Each frame is contiguous, with exactly one idle cycle between frames.
- RT_MASK = 4'b0100; port 2 valid continuously and port 1 FRAME high → port 2 frames are served repeatedly. After 8 port-2 grants, port 1 is granted with PROMOTED = 1, then its counter reads 0.
- Granted port 3 deasserts IN_VALID for 5 cycles mid-frame while port 0 becomes eligible → no switch; port 3 frame completes, then port 0 is granted.
- OUT_READY toggles randomly during a 6-word frame → all 6 words delivered in order. IN_READY[g] tracks OUT_READY; no duplicate or lost words.
- RESETn pulsed low at word 2 of a 4-word frame → all outputs return to reset values asynchronously. The next grant after release goes to the lowest-index eligible port.
